// File: rtl/core_v_xif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_v_xif_pkg
// Description : CORE-V-XIF interface structs and custom-0 decode constants
//               shared by the coprocessor responder and its ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package core_v_xif_pkg;

    // custom-0 major opcode and the funct3 codes the responder implements
    localparam logic [6:0] XIF_CUSTOM0_OPC = 7'b0001011;
    localparam logic [2:0] F3_ADD3         = 3'b000;
    localparam logic [2:0] F3_MAXU         = 3'b001;
    localparam logic [2:0] F3_CLZ          = 3'b010;

    // Issue request offered by the core (203 bits)
    typedef struct packed {
        logic [31:0]      instr;
        logic [1:0]       mode;
        logic [3:0]       id;
        logic [2:0][31:0] rs;
        logic [2:0]       rs_valid;
        logic [1:0][31:0] frs;
        logic [1:0]       frs_valid;
    } x_issue_req_t;

    // Issue response (7 bits)
    typedef struct packed {
        logic accept;
        logic writeback;
        logic float_op;
        logic dualwrite;
        logic dualread;
        logic loadstore;
        logic exc;
    } x_issue_resp_t;

    // Commit / kill strobe payload (5 bits)
    typedef struct packed {
        logic [3:0] id;
        logic       x_commit_kill;
    } x_commit_t;

    // Result returned to the core (50 bits)
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        float_op;
        logic        exc;
        logic [5:0]  exccode;
    } x_result_t;

endpackage
`default_nettype wire

// File: rtl/xif_copro_alu.sv
`default_nettype none
// ============================================================================
// Module      : xif_copro_alu
// Description : Combinational decode and compute for the custom-0 ops
//               ADD3, MAXU and CLZ. Reports whether the instruction is
//               ours and whether all required source operands are valid.
// Revision    : 1.0 - initial release
// ============================================================================
module xif_copro_alu
    import core_v_xif_pkg::*;
(
    input  logic [31:0]      i_instr,
    input  logic [2:0][31:0] i_rs,
    input  logic [2:0]       i_rs_valid,
    output logic             o_accept,
    output logic             o_ready_ok,
    output logic [31:0]      o_data
);

    logic       w_opc_ok;
    logic [2:0] w_funct3;
    logic [5:0] w_clz;
    logic       w_unused_instr;

    assign w_opc_ok = (i_instr[6:0] == XIF_CUSTOM0_OPC) && (i_instr[26:25] == 2'b00);
    assign w_funct3 = i_instr[14:12];

    // register fields and funct7 upper bits do not affect decode
    assign w_unused_instr = ^{i_instr[31:27], i_instr[24:15], i_instr[11:7]};

    // leading-zero count of rs1; the highest set bit wins, 32 when rs1 is zero
    always_comb begin
        w_clz = 6'd32;
        for (int b = 0; b < 32; b++) begin
            if (i_rs[0][b]) begin
                w_clz = 6'(31 - b);
            end
        end
    end

    // decode funct3, select the result and the operand-valid requirement
    always_comb begin
        o_accept   = 1'b0;
        o_ready_ok = 1'b0;
        o_data     = '0;
        if (w_opc_ok) begin
            unique case (w_funct3)
                F3_ADD3: begin
                    o_accept   = 1'b1;
                    o_ready_ok = &i_rs_valid;
                    o_data     = i_rs[0] + i_rs[1] + i_rs[2];
                end
                F3_MAXU: begin
                    o_accept   = 1'b1;
                    o_ready_ok = &i_rs_valid[1:0];
                    o_data     = (i_rs[0] >= i_rs[1]) ? i_rs[0] : i_rs[1];
                end
                F3_CLZ: begin
                    o_accept   = 1'b1;
                    o_ready_ok = i_rs_valid[0];
                    o_data     = {26'd0, w_clz};
                end
                default: begin
                    o_accept = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/xif_copro_responder.sv
`default_nettype none
// ============================================================================
// Module      : xif_copro_responder
// Description : CORE-V-XIF coprocessor responder. Accepts custom-0 ops,
//               computes them at issue, queues results in order and
//               releases each one only after the core commits its id.
//               Killed entries are dropped from the head without a result.
// Revision    : 1.0 - initial release
// ============================================================================
module xif_copro_responder
    import core_v_xif_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          x_issue_valid_i,
    output logic          x_issue_ready_o,
    input  x_issue_req_t  x_issue_req_i,
    output x_issue_resp_t x_issue_resp_o,
    input  logic          x_commit_valid_i,
    input  x_commit_t     x_commit_i,
    output logic          x_result_valid_o,
    input  logic          x_result_ready_i,
    output x_result_t     x_result_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    // queue storage
    logic [3:0]          r_id   [DEPTH];
    logic [4:0]          r_rd   [DEPTH];
    logic [31:0]         r_data [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [DEPTH-1:0]    r_committed;
    logic [DEPTH-1:0]    r_killed;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic                w_accept;
    logic                w_ready_ok;
    logic [31:0]         w_alu_data;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_head_commit;
    logic                w_head_kill;
    logic                w_hit;
    logic [c_ptr_w-1:0]  w_hit_idx;
    logic [c_ptr_w-1:0]  w_idx;
    logic                w_commit_hit;
    logic                w_commit_new;
    logic                w_unused_req;

    // mode and floating-point operands are not used by any implemented op
    assign w_unused_req = ^{x_issue_req_i.mode, x_issue_req_i.frs, x_issue_req_i.frs_valid};

    xif_copro_alu u_alu (
        .i_instr    (x_issue_req_i.instr),
        .i_rs       (x_issue_req_i.rs),
        .i_rs_valid (x_issue_req_i.rs_valid),
        .o_accept   (w_accept),
        .o_ready_ok (w_ready_ok),
        .o_data     (w_alu_data)
    );

    // Rejected instructions complete the handshake at once; accepted ones
    // wait for space and operands. A pop in this cycle does not free space
    // until the next one.
    assign w_full          = (r_count == c_cnt_w'(DEPTH));
    assign x_issue_ready_o = w_accept ? (!w_full && w_ready_ok) : 1'b1;
    assign w_push          = x_issue_valid_i && x_issue_ready_o && w_accept;

    assign w_head_commit    = r_valid[r_rd_ptr] && r_committed[r_rd_ptr] && !r_killed[r_rd_ptr];
    assign w_head_kill      = r_valid[r_rd_ptr] && r_killed[r_rd_ptr];
    assign x_result_valid_o = w_head_commit;
    assign w_pop            = w_head_kill || (w_head_commit && x_result_ready_i);

    // issue response is only meaningful during an accepted handshake
    always_comb begin
        x_issue_resp_o = '0;
        if (rst_ni && w_push) begin
            x_issue_resp_o.accept    = 1'b1;
            x_issue_resp_o.writeback = 1'b1;
        end
    end

    // find the oldest unresolved entry with the committed id, walking from the head
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + c_ptr_w'(i);
            if (!w_hit && r_valid[w_idx] && !r_committed[w_idx] && !r_killed[w_idx]
                && (r_id[w_idx] == x_commit_i.id)) begin
                w_hit     = 1'b1;
                w_hit_idx = w_idx;
            end
        end
    end

    // queued entries are older than the one being pushed, so they win a match
    assign w_commit_hit = x_commit_valid_i && w_hit;
    assign w_commit_new = x_commit_valid_i && !w_hit && w_push
                          && (x_commit_i.id == x_issue_req_i.id);

    // result payload comes straight from the head slot and is zero otherwise
    always_comb begin
        x_result_o = '0;
        if (w_head_commit) begin
            x_result_o.id   = r_id[r_rd_ptr];
            x_result_o.data = r_data[r_rd_ptr];
            x_result_o.rd   = r_rd[r_rd_ptr];
            x_result_o.we   = 1'b1;
        end
    end

    // payload capture at the accepted handshake; contents are qualified by r_valid
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_id[r_wr_ptr]   <= x_issue_req_i.id;
            r_rd[r_wr_ptr]   <= x_issue_req_i.instr[11:7];
            r_data[r_wr_ptr] <= w_alu_data;
        end
    end

    // per-entry valid / committed / killed state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid     <= '0;
            r_committed <= '0;
            r_killed    <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_rd_ptr]     <= 1'b0;
                r_committed[r_rd_ptr] <= 1'b0;
                r_killed[r_rd_ptr]    <= 1'b0;
            end
            if (w_commit_hit) begin
                if (x_commit_i.x_commit_kill) begin
                    r_killed[w_hit_idx] <= 1'b1;
                end else begin
                    r_committed[w_hit_idx] <= 1'b1;
                end
            end
            if (w_push) begin
                r_valid[r_wr_ptr]     <= 1'b1;
                r_committed[r_wr_ptr] <= w_commit_new && !x_commit_i.x_commit_kill;
                r_killed[r_wr_ptr]    <= w_commit_new && x_commit_i.x_commit_kill;
            end
        end
    end

    // circular-buffer pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
